mc_controller: RTL and testbench
================================

# mc_controller

Multicycle main control FSM for the MIPS64 core. It sits directly upstream of the ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and muxes. It also produces the 3-bit `aluop` that the ALU decoder combines with `funct` to select the ALU operation. Memory accesses are stalled by a single-bit ready handshake, and a retired-instruction counter is kept for performance monitoring.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: system clock, all state changes on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `op` in 6: instruction opcode, `instr[31:26]`, from the instruction register.
- `eq` in 1: register-file equality compare, rs == rt.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pcen` out 1: PC write enable.
- `irwrite` out 1: instruction register load.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `regwrite` out 1: register-file write enable.
- `regdst` out 1: destination register, 0 = rt, 1 = rd.
- `memtoreg` out 1: writeback source, 0 = ALUOut, 1 = Data.
- `alusrca` out 1: ALU A input, 0 = PC, 1 = A.
- `alusrcb` out 2: ALU B input, 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: next PC, 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop` out 3: to ALU decoder. Encodings: 000 ADD, 001 AND, 010 OR, 011 SLT, 100 DADD, 111 R-type.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `instret` out INSTRET_W: count of retired instructions.

## Operation
- Outputs are a Moore decode of the current state. The only exception is gating by `mem_ready` and `eq`, as noted below.
- Any signal not listed for a state is 0; `aluop` and `pcsrc` default to 000 and 00.
- Opcodes:
  - LW 100011, SW 101011, RTYPE 000000, BEQ 000100, J 000010.
  - ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, DADDI 011000.
- States and transitions:
  - FETCH:
    - Outputs: `alusrcb`=01, `aluop`=000.
    - `irwrite` = `pcen` = `mem_ready`.
    - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
  - DECODE:
    - Outputs: `alusrcb`=11, `aluop`=000.
    - Next state by opcode: LW/SW→MEMADR, RTYPE→RTYPEEX, BEQ→BEQEX, J→JEX, the five immediate ops→IMMEX.
    - Any other opcode: `illegal`=1, next state FETCH.
  - MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=000. LW→MEMRD, SW→MEMWR.
  - MEMRD: `iord`=1. Waits for `mem_ready`, then →MEMWB.
  - MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. →FETCH.
  - MEMWR:
    - Outputs: `iord`=1, `memwrite`=1.
    - `memwrite` is held until `mem_ready`, then →FETCH.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=111. →ALUWB.
  - ALUWB: `regwrite`=1, `regdst`=1. →FETCH.
  - IMMEX:
    - Outputs: `alusrca`=1, `alusrcb`=10.
    - `aluop` by opcode: ADDI 000, ANDI 001, ORI 010, SLTI 011, DADDI 100.
    - →IMMWB.
  - IMMWB: `regwrite`=1, `regdst`=0. →FETCH.
  - BEQEX: `alusrca`=1, `pcsrc`=01, `pcen`=`eq`. →FETCH.
  - JEX: `pcsrc`=10, `pcen`=1. →FETCH.
- `instret`:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR (on `mem_ready`), ALUWB, IMMWB, BEQEX or JEX.
  - Illegal-opcode returns do not count.
  - Wraps modulo 2^INSTRET_W with no saturation.
- `op` is sampled only in DECODE, MEMADR and IMMEX. The instruction register is stable there because `irwrite` is 0.

## Timing
- Reset:
  - When `reset_n`=0 at a rising edge: state←FETCH and `instret`←0.
  - While `reset_n`=0, all write enables (`pcen`, `irwrite`, `memwrite`, `regwrite`) and `illegal` are forced to 0. The mux outputs show FETCH values.
  - Reset mid-instruction (including a stalled MEMWR) abandons that instruction without counting it.
- Minimum latency with `mem_ready` tied to 1:
  - BEQ and J: 3 cycles.
  - R-type, immediate ops and SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. All other states ignore `mem_ready`.
- `illegal` is high exactly for the DECODE cycle. FETCH follows on the next cycle.

## Structure
- The package `mc_pkg` holds:
  - the state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, IMMEX, IMMWB, BEQEX, JEX);
  - opcode localparams;
  - aluop localparams, shared with the ALU decoder.
- The state register, next-state logic and counter live in `mc_controller`.
- The per-state output decode goes in the combinational sub-module `mc_outdec` (inputs: state, op, eq, mem_ready).

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with `mem_ready`=1, then release. Required: state FETCH, `instret`=0, no enables asserted during reset, `irwrite`=1 on the first cycle after release.
- **ADD then LW, `mem_ready`=1:**
  - ADD (op 000000): `aluop`=111 in cycle 3, `regwrite`=`regdst`=1 in cycle 4.
  - LW: `memtoreg`=1 in cycle 5.
  - `instret`=2 afterwards.
- **SW with `mem_ready` low for 3 cycles in MEMWR:** `memwrite`=1 for 4 consecutive cycles, then FETCH; `instret`+1.
- **BEQ:** with `eq`=1, `pcen`=1 and `pcsrc`=01 in BEQEX. With `eq`=0, `pcen`=0. Both cases take 3 cycles.
- **Immediate ops:** ANDI, ORI, SLTI and DADDI each give `aluop` 001, 010, 011, 100 respectively in IMMEX.
- **Illegal opcode and counter wrap:**
  - op 111111: `illegal` pulses once, FETCH next, `instret` unchanged.
  - With INSTRET_W=4: 16 J instructions bring `instret` back to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle main controller: state encoding,
// opcodes and the aluop codes understood by the ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, ALUWB, IMMEX, IMMWB, BEQEX, JEX
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_DADDI = 6'b011000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_DADD  = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_SLTI:  return ALU_SLT;
      OP_DADDI: return ALU_DADD;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_outdec.sv
// Per-state Moore output decode; only mem_ready (FETCH) and eq (BEQEX)
// gate individual enables.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        pcen,
  output logic        irwrite,
  output logic        iord,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  aluop,
  output logic        illegal
);

  function automatic logic known_op(input logic [5:0] o);
    case (o)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    pcen     = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    illegal  = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !known_op(op);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALU_RTYPE;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = imm_aluop(op);
      end
      IMMWB: regwrite = 1'b1;
      BEQEX: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        pcen    = eq;
      end
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle main control FSM: state register, next-state logic and the
// retired-instruction counter. Output decode lives in mc_outdec.
module mc_controller
  import mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic                 eq,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 irwrite,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [2:0]           aluop,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output state_t               state
);

  state_t state_q, state_next;
  state_t dec_state;
  logic   retire;
  logic   pcen_raw, irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      instret <= '0;
    end else begin
      state_q <= state_next;
      if (retire) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next = state_q;
    retire     = 1'b0;
    case (state_q)
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_J:         state_next = JEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI: state_next = IMMEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_next = MEMWB;
      MEMWR: begin
        if (mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      RTYPEEX: state_next = ALUWB;
      IMMEX:   state_next = IMMWB;
      MEMWB, ALUWB, IMMWB, BEQEX, JEX: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset is synchronous, so the register may not yet hold FETCH during the
  // first reset cycle; the muxes show FETCH values and enables are masked.
  assign dec_state = reset_n ? state_q : FETCH;

  mc_outdec u_outdec (
    .state     (dec_state),
    .op        (op),
    .eq        (eq),
    .mem_ready (mem_ready),
    .pcen      (pcen_raw),
    .irwrite   (irwrite_raw),
    .iord      (iord),
    .memwrite  (memwrite_raw),
    .regwrite  (regwrite_raw),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .illegal   (illegal_raw)
  );

  assign pcen     = pcen_raw     & reset_n;
  assign irwrite  = irwrite_raw  & reset_n;
  assign memwrite = memwrite_raw & reset_n;
  assign regwrite = regwrite_raw & reset_n;
  assign illegal  = illegal_raw  & reset_n;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller (INSTRET_W=4 to reach wrap).
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'b0;
  logic       eq = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] instret;
  state_t     state;

  always #5 clk = ~clk;

  mc_controller #(.INSTRET_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .eq(eq), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .illegal(illegal), .instret(instret), .state(state)
  );

  // {pcen,irwrite,iord,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,aluop,illegal}
  logic [15:0] act;
  assign act = {pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, aluop, illegal};

  localparam logic [15:0] O_FETCH  = 16'hC040;
  localparam logic [15:0] O_FSTALL = 16'h0040;
  localparam logic [15:0] O_DEC    = 16'h00C0;
  localparam logic [15:0] O_DECILL = 16'h00C1;
  localparam logic [15:0] O_MEMADR = 16'h0180;
  localparam logic [15:0] O_MEMRD  = 16'h2000;
  localparam logic [15:0] O_MEMWB  = 16'h0A00;
  localparam logic [15:0] O_MEMWR  = 16'h3000;
  localparam logic [15:0] O_RTEX   = 16'h010E;
  localparam logic [15:0] O_ALUWB  = 16'h0C00;
  localparam logic [15:0] O_IMMWB  = 16'h0800;
  localparam logic [15:0] O_BEQ1   = 16'h8110;
  localparam logic [15:0] O_BEQ0   = 16'h0110;
  localparam logic [15:0] O_JEX    = 16'h8020;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        eq;
    logic        rdy;
    logic        full;
    state_t      st;
    logic [15:0] out;
    logic [3:0]  ret;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  task automatic add(input logic r, input logic [5:0] o, input logic e, input logic rd,
                     input state_t s, input logic [15:0] ov, input logic [3:0] rt);
    vec_t v;
    v = '{rst_n: r, op: o, eq: e, rdy: rd, full: 1'b1, st: s, out: ov, ret: rt};
    tbl.push_back(v);
  endtask

  task automatic fd(input logic [5:0] o, input logic [3:0] rt);
    add(1, o, 0, 1, FETCH, O_FETCH, rt);
    add(1, o, 0, 1, DECODE, O_DEC, rt);
  endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  initial begin
    vec_t v0;
    int   mw_cnt;
    // reset: first cycle state/counter unknown, outputs still defined
    v0 = '{rst_n: 0, op: 0, eq: 0, rdy: 1, full: 0, st: FETCH, out: O_FSTALL, ret: 0};
    tbl.push_back(v0);
    add(0, 0, 0, 1, FETCH, O_FSTALL, 0);
    // ADD then LW, mem_ready=1
    fd(OP_RTYPE, 0);
    add(1, OP_RTYPE, 0, 1, RTYPEEX, O_RTEX, 0);
    add(1, OP_RTYPE, 0, 1, ALUWB, O_ALUWB, 0);
    fd(OP_LW, 1);
    add(1, OP_LW, 0, 1, MEMADR, O_MEMADR, 1);
    add(1, OP_LW, 0, 1, MEMRD, O_MEMRD, 1);
    add(1, OP_LW, 0, 1, MEMWB, O_MEMWB, 1);
    // SW with a fetch stall and 3 MEMWR stall cycles
    add(1, OP_SW, 0, 0, FETCH, O_FSTALL, 2);
    fd(OP_SW, 2);
    add(1, OP_SW, 0, 0, MEMADR, O_MEMADR, 2);
    for (int i = 0; i < 3; i++) add(1, OP_SW, 0, 0, MEMWR, O_MEMWR, 2);
    add(1, OP_SW, 0, 1, MEMWR, O_MEMWR, 2);
    // LW with one MEMRD stall; mem_ready low in DECODE must be ignored
    add(1, OP_LW, 0, 1, FETCH, O_FETCH, 3);
    add(1, OP_LW, 0, 0, DECODE, O_DEC, 3);
    add(1, OP_LW, 0, 1, MEMADR, O_MEMADR, 3);
    add(1, OP_LW, 0, 0, MEMRD, O_MEMRD, 3);
    add(1, OP_LW, 0, 1, MEMRD, O_MEMRD, 3);
    add(1, OP_LW, 0, 0, MEMWB, O_MEMWB, 3);
    // BEQ taken / not taken
    fd(OP_BEQ, 4);
    add(1, OP_BEQ, 1, 1, BEQEX, O_BEQ1, 4);
    fd(OP_BEQ, 5);
    add(1, OP_BEQ, 0, 1, BEQEX, O_BEQ0, 5);
    // immediate ops
    fd(OP_ADDI, 6);  add(1, OP_ADDI, 0, 1, IMMEX, 16'h0180, 6);  add(1, OP_ADDI, 0, 1, IMMWB, O_IMMWB, 6);
    fd(OP_ANDI, 7);  add(1, OP_ANDI, 0, 1, IMMEX, 16'h0182, 7);  add(1, OP_ANDI, 0, 1, IMMWB, O_IMMWB, 7);
    fd(OP_ORI, 8);   add(1, OP_ORI, 0, 1, IMMEX, 16'h0184, 8);   add(1, OP_ORI, 0, 1, IMMWB, O_IMMWB, 8);
    fd(OP_SLTI, 9);  add(1, OP_SLTI, 0, 1, IMMEX, 16'h0186, 9);  add(1, OP_SLTI, 0, 1, IMMWB, O_IMMWB, 9);
    fd(OP_DADDI, 10); add(1, OP_DADDI, 0, 1, IMMEX, 16'h0188, 10); add(1, OP_DADDI, 0, 1, IMMWB, O_IMMWB, 10);
    // illegal opcodes: one-cycle pulse, no retire
    add(1, 6'b111111, 0, 1, FETCH, O_FETCH, 11);
    add(1, 6'b111111, 0, 1, DECODE, O_DECILL, 11);
    add(1, 6'b000001, 0, 1, FETCH, O_FETCH, 11);
    add(1, 6'b000001, 0, 1, DECODE, O_DECILL, 11);
    // reset in the middle of a stalled SW
    fd(OP_SW, 11);
    add(1, OP_SW, 0, 0, MEMADR, O_MEMADR, 11);
    add(1, OP_SW, 0, 0, MEMWR, O_MEMWR, 11);
    add(0, OP_SW, 0, 0, MEMWR, O_FSTALL, 11);
    // 16 jumps wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      fd(OP_J, 4'(i));
      add(1, OP_J, 0, 1, JEX, O_JEX, 4'(i));
    end
    add(1, OP_SW, 0, 0, FETCH, O_FSTALL, 0);

    reset_n = 1'b0;
    #1;
    foreach (tbl[k]) begin
      reset_n   = tbl[k].rst_n;
      op        = tbl[k].op;
      eq        = tbl[k].eq;
      mem_ready = tbl[k].rdy;
      @(negedge clk);
      check($sformatf("out[%0d]", k), 32'(act), 32'(tbl[k].out));
      if (tbl[k].full) begin
        check($sformatf("state[%0d]", k), 32'(state), 32'(tbl[k].st));
        check($sformatf("instret[%0d]", k), 32'(instret), 32'(tbl[k].ret));
      end
      @(posedge clk);
      #1;
    end

    // hand sequence: SW with 3 stall cycles gives 4 consecutive memwrite cycles
    mw_cnt = 0;
    op = OP_SW;
    eq = 1'b0;
    for (int c = 0; c < 7; c++) begin
      mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (memwrite) mw_cnt++;
      if (c == 6) check("sw_memwrite_last", 32'(memwrite), 32'd1);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
    check("sw_end_state", 32'(state), 32'(FETCH));
    check("sw_instret", 32'(instret), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
